seq_generator: RTL

Serial frame transmitter that drives the single-bit `x` stream consumed by `seq_detector`. On a start request it emits a fixed sync marker (default 0110) followed by a latched data word, MSB first, one bit per clock. It pairs with the 0110 Mealy detector: it is the bench-side and system-side source of the pattern the detector recognises.

---
 rtl/seq_generator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_generator.sv
// Serial frame transmitter: sync marker then latched payload MSB first (optional even-parity bit), one bit per clock.
// Latency: first frame bit on x one cycle after the accepting edge; done pulses the cycle after the last bit.
// Backpressure: none; start is ignored while busy (no queuing), accepted again in the cycle after done.
// Optional feature: define SEQ_GEN_PARITY_EN to append an even-parity bit after the payload.
module seq_generator #(
    parameter int                SYNC_W = 4,
    parameter logic [SYNC_W-1:0] SYNC   = 4'b0110,
    parameter int                DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              x,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    // Counter must reach the longer of the two segments.
    localparam int CNT_MAX = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // The state names the bit that the next edge emits: the accepting edge
    // in IDLE emits sync bit 0, SYNC emits the rest of the marker, DATA the
    // payload, PAR the parity bit and FIN the done pulse. This keeps every
    // output registered while the next accept lands exactly on the edge
    // after the done pulse.
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
`ifdef SEQ_GEN_PARITY_EN
        S_PAR,
`endif
        S_FIN
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   shreg;
    logic [SYNC_W-1:0]   sync_sh;
`ifdef SEQ_GEN_PARITY_EN
    logic                par;
`endif

    // Frame FSM with registered serial outputs; reset aborts any frame silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            sync_sh <= '0;
            x       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Latch the payload and emit the first marker bit now.
                        shreg   <= data;
                        sync_sh <= SYNC << 1;
`ifdef SEQ_GEN_PARITY_EN
                        par     <= ^data;
`endif
                        x       <= SYNC[SYNC_W-1];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        if (SYNC_W > 1) begin
                            cnt   <= CNT_ONE;
                            state <= S_SYNC;
                        end else begin
                            cnt   <= '0;
                            state <= S_DATA;
                        end
                    end else begin
                        x     <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end

                S_SYNC: begin
                    x       <= sync_sh[SYNC_W-1];
                    sync_sh <= sync_sh << 1;
                    if (cnt == SYNC_LAST) begin
                        cnt   <= '0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    x     <= shreg[DATA_W-1];
                    shreg <= shreg << 1;
                    if (cnt == DATA_LAST) begin
                        cnt   <= '0;
`ifdef SEQ_GEN_PARITY_EN
                        state <= S_PAR;
`else
                        state <= S_FIN;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

`ifdef SEQ_GEN_PARITY_EN
                S_PAR: begin
                    x     <= par;
                    state <= S_FIN;
                end
`endif

                S_FIN: begin
                    // One idle bit carrying the done pulse; start is not looked at here.
                    x     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    x     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
